// File: rtl/laplacian_pkg.sv
// laplacian_pkg: shared widths, saturation limits and FSM states for the 3x3 Laplacian kernel
package laplacian_pkg;
    localparam int PIX_W = 8;
    localparam int OUT_W = 9;
    localparam int OUT_MAX = 255;
    localparam int OUT_MIN = -256;
    typedef enum logic [1:0] {IDLE, SUM, OUT, DONE} state_t;
endpackage

// File: rtl/laplacian_3x3_sat_signed.sv
// sat_signed: clamps a signed IN_W-bit value into the signed W-bit result range
module sat_signed
    import laplacian_pkg::*;
#(
    parameter int IN_W = 11,
    parameter int W = OUT_W
) (
    input  logic signed [IN_W-1:0] in_i,
    output logic signed [W-1:0]    out_o
);
    localparam logic signed [IN_W-1:0] MAX_V = IN_W'(OUT_MAX);
    localparam logic signed [IN_W-1:0] MIN_V = IN_W'(OUT_MIN);
    assign out_o = (in_i > MAX_V) ? W'(OUT_MAX) : (in_i < MIN_V) ? W'(OUT_MIN) : in_i[W-1:0];
endmodule

// File: rtl/laplacian_3x3.sv
// laplacian_3x3: registered 4-neighbour Laplacian with en/done level handshake
module laplacian_3x3
    import laplacian_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic [PIX_W-1:0]        data_i_0,
    input  logic [PIX_W-1:0]        data_i_1,
    input  logic [PIX_W-1:0]        data_i_2,
    input  logic [PIX_W-1:0]        data_i_3,
    input  logic [PIX_W-1:0]        data_i_4,
    input  logic [PIX_W-1:0]        data_i_5,
    input  logic [PIX_W-1:0]        data_i_6,
    input  logic [PIX_W-1:0]        data_i_7,
    input  logic [PIX_W-1:0]        data_i_8,
    output logic signed [OUT_W-1:0] data_o,
    output logic                    sonuc_done
);
    state_t state_q, state_d;
    logic [PIX_W-1:0] pix_q [9];
    logic [PIX_W-1:0] pix_d [9];
    logic [PIX_W+1:0] nsum_q, nsum_d, c4_q, c4_d;
    logic signed [OUT_W-1:0] data_q, data_d, sat_o;
    logic done_q, done_d;
    logic signed [PIX_W+2:0] r;
    assign r = $signed({1'b0, c4_q}) - $signed({1'b0, nsum_q});
    sat_signed #(.IN_W(PIX_W + 3), .W(OUT_W)) u_sat (.in_i(r), .out_o(sat_o));
    always_comb begin
        state_d = state_q;
        pix_d = pix_q;
        nsum_d = nsum_q;
        c4_d = c4_q;
        data_d = data_q;
        done_d = done_q;
        case (state_q)
            IDLE: if (en_i) begin
                pix_d = '{data_i_0, data_i_1, data_i_2, data_i_3, data_i_4,
                          data_i_5, data_i_6, data_i_7, data_i_8};
                state_d = SUM;
            end
            SUM: begin
                nsum_d = (PIX_W+2)'(pix_q[1]) + (PIX_W+2)'(pix_q[3])
                       + (PIX_W+2)'(pix_q[5]) + (PIX_W+2)'(pix_q[7]);
                c4_d = {pix_q[4], 2'b00};
                state_d = en_i ? OUT : IDLE;
            end
            OUT: begin
                data_d = en_i ? sat_o : data_q;
                done_d = en_i;
                state_d = en_i ? DONE : IDLE;
            end
            DONE: begin
                done_d = en_i;
                state_d = en_i ? DONE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            pix_q <= '{default: '0};
            nsum_q <= '0;
            c4_q <= '0;
            data_q <= '0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pix_q <= pix_d;
            nsum_q <= nsum_d;
            c4_q <= c4_d;
            data_q <= data_d;
            done_q <= done_d;
        end
    end
    assign data_o = data_q;
    assign sonuc_done = done_q;
endmodule

// File: tb/tb_laplacian_3x3.sv
// tb_laplacian_3x3: directed scoreboard bench for the 3x3 Laplacian kernel
module tb_laplacian_3x3;
    logic clk_i = 0;
    logic rst_i = 0;
    logic en_i = 0;
    logic [7:0] d [9];
    logic signed [8:0] data_o;
    logic sonuc_done;
    logic [8:0] sb [$];
    logic [8:0] last;
    int total = 0;
    int bad = 0;

    laplacian_3x3 dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
        .data_i_0(d[0]), .data_i_1(d[1]), .data_i_2(d[2]),
        .data_i_3(d[3]), .data_i_4(d[4]), .data_i_5(d[5]),
        .data_i_6(d[6]), .data_i_7(d[7]), .data_i_8(d[8]),
        .data_o(data_o), .sonuc_done(sonuc_done)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] model(input logic [8:0][7:0] p);
        int r;
        r = 4 * int'(p[4]) - (int'(p[1]) + int'(p[3]) + int'(p[5]) + int'(p[7]));
        r = (r > 255) ? 255 : (r < -256) ? -256 : r;
        return 9'(r);
    endfunction

    task automatic cyc();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic drive(input logic [8:0][7:0] p);
        for (int i = 0; i < 9; i++) d[i] = p[i];
        en_i = 1;
    endtask

    task automatic run_window(input string tag, input logic [8:0][7:0] p);
        int n;
        drive(p);
        sb.push_back(model(p));
        n = 0;
        do begin
            cyc();
            n++;
            if (n == 1) for (int i = 0; i < 9; i++) d[i] = 8'($urandom);
        end while (!sonuc_done && n < 10);
        check({tag, "_latency"}, n, 3);
        last = sb.pop_front();
        check(tag, $unsigned(data_o), last);
    endtask

    task automatic release_en(input string tag);
        en_i = 0;
        cyc();
        check({tag, "_done_fall"}, sonuc_done, 0);
    endtask

    initial begin
        for (int i = 0; i < 9; i++) d[i] = 0;
        cyc();
        cyc();
        check("rst_data", $unsigned(data_o), 0);
        check("rst_done", sonuc_done, 0);
        rst_i = 1;
        cyc();

        run_window("flat", {9{8'd100}});
        release_en("flat");
        run_window("gradient", {8'd200, 8'd40, 8'd200, 8'd30, 8'd50, 8'd20, 8'd200, 8'd10, 8'd200});
        release_en("gradient");
        run_window("gradient_nocorner", {8'd0, 8'd40, 8'd0, 8'd30, 8'd50, 8'd20, 8'd0, 8'd10, 8'd0});
        release_en("gradient_nocorner");
        run_window("pos_sat", {8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0});
        release_en("pos_sat");
        run_window("neg_sat", {8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255});
        release_en("neg_sat");
        check("neg_sat_value", $unsigned(data_o), 9'h100);
        run_window("small_neg", {8'd0, 8'd9, 8'd0, 8'd7, 8'd3, 8'd5, 8'd0, 8'd1, 8'd0});

        for (int i = 0; i < 36; i++) begin
            cyc();
            check("hold_done", sonuc_done, 1);
            check("hold_data", $unsigned(data_o), last);
        end
        release_en("hold");
        cyc();
        run_window("after_gap", {8'd1, 8'd2, 8'd3, 8'd4, 8'd60, 8'd6, 8'd7, 8'd8, 8'd9});
        release_en("after_gap");

        drive({9{8'd255}} ^ {8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0});
        cyc();
        en_i = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("abort_sum_done", sonuc_done, 0);
        end
        check("abort_sum_data", $unsigned(data_o), last);

        drive({9{8'd0}} | {8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0});
        cyc();
        cyc();
        en_i = 0;
        cyc();
        check("abort_out_done", sonuc_done, 0);
        check("abort_out_data", $unsigned(data_o), last);
        cyc();

        run_window("pre_reset", {8'd0, 8'd1, 8'd0, 8'd1, 8'd30, 8'd1, 8'd0, 8'd1, 8'd0});
        rst_i = 0;
        cyc();
        check("mid_rst_data", $unsigned(data_o), 0);
        check("mid_rst_done", sonuc_done, 0);
        rst_i = 1;
        en_i = 0;
        cyc();
        run_window("post_reset", {8'd5, 8'd10, 8'd5, 8'd10, 8'd20, 8'd10, 8'd5, 8'd10, 8'd5});
        release_en("post_reset");
        check("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
